// File: rtl/player_motion_pkg.sv
// Shared definitions for the player motion slice: coordinate width, screen
// limits, vertical state encoding and the wall bundle field layout.
`timescale 1ns/1ps
package player_motion_pkg;

  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t X_MAX = 11'd639;
  localparam coord_t Y_MAX = 11'd479;

  localparam logic [1:0] ST_GROUND  = 2'd0;
  localparam logic [1:0] ST_JUMP    = 2'd1;
  localparam logic [1:0] ST_FALL    = 2'd2;
  localparam logic [1:0] ST_DESCEND = 2'd3;

  // Wall bundle: [43:33] bottom, [32:22] top, [21:11] right, [10:0] left
  localparam int WALL_W          = 44;
  localparam int WALL_LEFT_LSB   = 0;
  localparam int WALL_RIGHT_LSB  = 11;
  localparam int WALL_TOP_LSB    = 22;
  localparam int WALL_BOTTOM_LSB = 33;

  typedef struct packed {
    coord_t bottom;
    coord_t top;
    coord_t right;
    coord_t left;
  } wall_t;

  function automatic coord_t wall_top(input wall_t w);
    return w.top;
  endfunction

endpackage

// File: rtl/player_hstep.sv
// Horizontal step: one frame's left/right move with saturation at both
// screen edges, so the column never wraps.
`timescale 1ns/1ps
module player_hstep
  import player_motion_pkg::*;
#(
  parameter int STEP  = 2,
  parameter int X_LIM = 624
) (
  input  logic [COORD_W-1:0] x_in,
  input  logic               btn_left,
  input  logic               btn_right,
  output logic [COORD_W-1:0] x_out
);

  localparam coord_t STEP_C  = coord_t'(STEP);
  localparam coord_t X_LIM_C = coord_t'(X_LIM);

  // Clamp is decided before the add/subtract so the result stays in range.
  always_comb begin
    x_out = x_in;
    if (btn_left && !btn_right) begin
      if (x_in < STEP_C) begin
        x_out = 11'd0;
      end else begin
        x_out = x_in - STEP_C;
      end
    end else if (btn_right && !btn_left) begin
      if (x_in > (X_LIM_C - STEP_C)) begin
        x_out = X_LIM_C;
      end else begin
        x_out = x_in + STEP_C;
      end
    end else begin
      x_out = x_in;
    end
  end

endmodule

// File: rtl/player_motion.sv
// Per-frame player position controller: horizontal stepping plus a
// ground/jump/fall/descend machine that descends one pixel per clock.
`timescale 1ns/1ps
module player_motion
  import player_motion_pkg::*;
#(
  parameter int PLAYER_W    = 16,
  parameter int PLAYER_H    = 16,
  parameter int START_X     = 320,
  parameter int START_Y     = 100,
  parameter int STEP        = 2,
  parameter int JUMP_FRAMES = 20,
  parameter int GRAVITY_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_jump,
  input  logic               collide,
  output logic [COORD_W-1:0] topy,
  output logic [COORD_W-1:0] bottomy,
  output logic [COORD_W-1:0] leftx,
  output logic [COORD_W-1:0] rightx,
  output logic [1:0]         state,
  output logic               airborne
);

  localparam int JC_W = $clog2(JUMP_FRAMES + 1);
  localparam int VW   = $clog2(GRAVITY_MAX + 1);

  localparam coord_t           STEP_C   = coord_t'(STEP);
  localparam coord_t           W_M1     = coord_t'(PLAYER_W - 1);
  localparam coord_t           H_M1     = coord_t'(PLAYER_H - 1);
  localparam coord_t           START_XC = coord_t'(START_X);
  localparam coord_t           START_YC = coord_t'(START_Y);
  localparam logic [JC_W-1:0]  JUMP_C   = JC_W'(JUMP_FRAMES);
  localparam logic [VW-1:0]    GMAX_C   = VW'(GRAVITY_MAX);
  localparam logic [VW-1:0]    VEL_ONE  = VW'(1);

  coord_t          x_q, x_d, y_q, y_d;
  logic [1:0]      state_q, state_d;
  logic [JC_W-1:0] jump_cnt_q, jump_cnt_d;
  logic [VW-1:0]   vel_q, vel_d, step_cnt_q, step_cnt_d;
  coord_t          x_step_s, bottomy_s;
  logic [VW-1:0]   vel_inc_s;

  player_hstep #(
    .STEP  (STEP),
    .X_LIM (int'(X_MAX) - PLAYER_W + 1)
  ) u_hstep (
    .x_in      (x_q),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .x_out     (x_step_s)
  );

  assign bottomy_s = y_q + H_M1;
  assign vel_inc_s = (vel_q >= GMAX_C) ? GMAX_C : (vel_q + VEL_ONE);

  assign topy     = y_q;
  assign bottomy  = bottomy_s;
  assign leftx    = x_q;
  assign rightx   = x_q + W_M1;
  assign state    = state_q;
  assign airborne = (state_q != ST_GROUND);

  // Next-state logic for position and the vertical state machine.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    state_d    = state_q;
    jump_cnt_d = jump_cnt_q;
    vel_d      = vel_q;
    step_cnt_d = step_cnt_q;
    if (frame_tick) begin
      x_d = x_step_s;
    end else begin
      x_d = x_q;
    end
    case (state_q)
      ST_GROUND: begin
        if (!frame_tick) begin
          state_d = ST_GROUND;
        end else if (btn_jump) begin
          state_d    = ST_JUMP;
          jump_cnt_d = JUMP_C;
        end else if (!collide && (bottomy_s < Y_MAX)) begin
          state_d = ST_FALL;
          vel_d   = {VW{1'b0}};
        end else begin
          state_d = ST_GROUND;
        end
      end
      ST_JUMP: begin
        if (!frame_tick) begin
          state_d = ST_JUMP;
        end else if ((jump_cnt_q == {JC_W{1'b0}}) || (y_q < STEP_C)) begin
          state_d = ST_FALL;
          vel_d   = {VW{1'b0}};
        end else begin
          y_d        = y_q - STEP_C;
          jump_cnt_d = jump_cnt_q - {{(JC_W-1){1'b0}}, 1'b1};
        end
      end
      ST_FALL: begin
        if (frame_tick) begin
          vel_d      = vel_inc_s;
          step_cnt_d = vel_inc_s;
          state_d    = ST_DESCEND;
        end else begin
          state_d = ST_FALL;
        end
      end
      ST_DESCEND: begin
        // collide reflects this cycle's registers, so the stop row is exact.
        if (collide) begin
          state_d    = ST_GROUND;
          vel_d      = {VW{1'b0}};
          step_cnt_d = {VW{1'b0}};
        end else if (bottomy_s == Y_MAX) begin
          state_d = ST_GROUND;
          vel_d   = {VW{1'b0}};
        end else if (step_cnt_q == {VW{1'b0}}) begin
          state_d = ST_FALL;
        end else begin
          y_d        = y_q + 11'd1;
          step_cnt_d = step_cnt_q - VEL_ONE;
        end
      end
      default: begin
        state_d = ST_FALL;
        vel_d   = {VW{1'b0}};
      end
    endcase
  end

  // State and position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= START_XC;
      y_q        <= START_YC;
      state_q    <= ST_FALL;
      jump_cnt_q <= {JC_W{1'b0}};
      vel_q      <= {VW{1'b0}};
      step_cnt_q <= {VW{1'b0}};
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      state_q    <= state_d;
      jump_cnt_q <= jump_cnt_d;
      vel_q      <= vel_d;
      step_cnt_q <= step_cnt_d;
    end
  end

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: a frame-level position model and a
// wall/collision environment, driven by directed and randomized button steps.
`timescale 1ns/1ps
module tb_player_motion;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_jump = 1'b0;
  logic        collide;
  logic [10:0] topy, bottomy, leftx, rightx;
  logic [1:0]  state;
  logic        airborne;

  int n_cmp = 0;
  int n_err = 0;

  int wall_en  = 0;
  int wall_top = 140;
  int wall_l   = 300;
  int wall_r   = 400;

  localparam int M_GROUND = 0;
  localparam int M_RISE   = 1;
  localparam int M_FALL   = 2;

  int mx, my, mv, mrise, mphase;

  player_motion dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .collide    (collide),
    .topy       (topy),
    .bottomy    (bottomy),
    .leftx      (leftx),
    .rightx     (rightx),
    .state      (state),
    .airborne   (airborne)
  );

  always #5 clk = ~clk;

  always_comb begin
    collide = (wall_en != 0) && (int'(bottomy) + 1 == wall_top) &&
              (int'(leftx) <= wall_r) && (int'(rightx) >= wall_l);
  end

  function automatic bit supported(input int x, input int y);
    return (wall_en != 0) && (y + 16 == wall_top) && (x <= wall_r) && (x + 15 >= wall_l);
  endfunction

  function automatic bit at_floor(input int y);
    return (y + 15 >= 479);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("topy", {21'd0, topy}, my);
    chk("bottomy", {21'd0, bottomy}, my + 15);
    chk("leftx", {21'd0, leftx}, mx);
    chk("rightx", {21'd0, rightx}, mx + 15);
    chk("state", {30'd0, state}, mphase);
    chk("airborne", {31'd0, airborne}, (mphase != M_GROUND) ? 1 : 0);
  endtask

  task automatic model_reset();
    mx = 320; my = 100; mphase = M_FALL; mv = 0; mrise = 0;
  endtask

  // One frame of player behaviour, written in pixels and frames.
  task automatic model_step(input bit l, input bit r, input bit j);
    int  nx;
    bit  landed;
    nx = mx;
    if (l && !r) nx = (mx < 2) ? 0 : mx - 2;
    else if (r && !l) nx = (mx + 2 > 624) ? 624 : mx + 2;
    case (mphase)
      M_GROUND: begin
        if (j) begin
          mphase = M_RISE; mrise = 20;
        end else if (!supported(mx, my) && !at_floor(my)) begin
          mphase = M_FALL; mv = 0;
        end
      end
      M_RISE: begin
        if (mrise == 0 || my < 2) begin
          mphase = M_FALL; mv = 0;
        end else begin
          my = my - 2; mrise = mrise - 1;
        end
      end
      default: begin
        mv = (mv + 1 > 4) ? 4 : mv + 1;
        landed = 1'b0;
        for (int k = 0; k < mv; k++) begin
          if (supported(nx, my) || at_floor(my)) begin
            landed = 1'b1;
            break;
          end
          my = my + 1;
        end
        if (!landed && (supported(nx, my) || at_floor(my))) landed = 1'b1;
        if (landed) begin
          mphase = M_GROUND; mv = 0;
        end else begin
          mphase = M_FALL;
        end
      end
    endcase
    mx = nx;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick(input bit l, input bit r, input bit j);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    model_step(l, r, j);
    repeat (8) @(negedge clk);
    check_model();
  endtask

  initial begin
    do_reset();

    // Fall onto a wall at row 140 from the reset position.
    wall_en = 1; wall_top = 140;
    for (int i = 0; i < 40 && mphase != M_GROUND; i++) tick(1'b0, 1'b0, 1'b0);
    chk("land_wall_bottomy", {21'd0, bottomy}, 139);
    chk("land_wall_state", {30'd0, state}, 0);

    // Full jump, then a fall with jump held (no double jump).
    tick(1'b0, 1'b0, 1'b1);
    chk("jump_start_state", {30'd0, state}, 1);
    repeat (20) tick(1'b0, 1'b0, 1'b0);
    chk("jump_apex_topy", {21'd0, topy}, 84);
    tick(1'b0, 1'b0, 1'b0);
    chk("jump_end_state", {30'd0, state}, 2);
    for (int i = 0; i < 40 && mphase != M_GROUND; i++) tick(1'b0, 1'b0, 1'b1);
    chk("reland_bottomy", {21'd0, bottomy}, 139);

    // Both buttons: no horizontal move.
    repeat (5) tick(1'b1, 1'b1, 1'b0);
    chk("both_btn_leftx", {21'd0, leftx}, 320);

    // Walk right off the wall edge, fall to the floor, saturate at the edge.
    repeat (200) tick(1'b0, 1'b1, 1'b0);
    chk("sat_leftx", {21'd0, leftx}, 624);
    chk("sat_rightx", {21'd0, rightx}, 639);
    chk("floor_bottomy", {21'd0, bottomy}, 479);
    chk("floor_state", {30'd0, state}, 0);

    // Randomized wandering checked frame by frame against the model.
    repeat (150) tick(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 7) == 0));

    // Climb toward the top of the screen using walls placed under the player.
    do_reset();
    wall_en = 1; wall_top = 116;
    tick(1'b0, 1'b0, 1'b0);
    chk("ledge100_state", {30'd0, state}, 0);
    tick(1'b0, 1'b0, 1'b1);
    repeat (20) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    wall_top = 76;
    tick(1'b0, 1'b0, 1'b0);
    chk("ledge60_topy", {21'd0, topy}, 60);
    tick(1'b0, 1'b0, 1'b1);
    repeat (20) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    wall_top = 36;
    tick(1'b0, 1'b0, 1'b0);
    chk("ledge20_state", {30'd0, state}, 0);
    tick(1'b0, 1'b0, 1'b1);
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    chk("top_clip_topy", {21'd0, topy}, 0);
    tick(1'b0, 1'b0, 1'b0);
    chk("top_clip_fall", {30'd0, state}, 2);
    chk("top_clip_topy_hold", {21'd0, topy}, 0);

    // Reset asserted while descending.
    wall_en = 0;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("pre_reset_descend", {30'd0, state}, 3);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/player_motion.md
Name: player_motion

Overview:
- Per-frame player position controller.
- Owns the player's box coordinates (topy, bottomy, leftx, rightx) and drives them into the player collision stage.
- Consumes that stage's collide flag to decide landing.
- Moves horizontally from buttons; runs a ground/jump/fall state machine with one-pixel-per-clock descent, so landing can never overshoot a wall top.

Parameters:
- PLAYER_W, 16, player box width in pixels
- PLAYER_H, 16, player box height in pixels
- START_X, 320, leftx after reset
- START_Y, 100, topy after reset
- X_MAX, 639, rightmost legal pixel column
- Y_MAX, 479, floor row; bottomy never exceeds it
- STEP, 2, horizontal pixels per frame and rise pixels per jump frame
- JUMP_FRAMES, 20, frames of rise per jump
- GRAVITY_MAX, 4, maximum fall pixels per frame

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse, once per video frame
- btn_left  in  1  move-left request, level
- btn_right  in  1  move-right request, level
- btn_jump  in  1  jump request, level
- collide  in  1  from collision stage; 1 = bottomy+1 equals a wall top within its x span; combinational on current outputs
- topy  out  11  player top row
- bottomy  out  11  topy + PLAYER_H - 1
- leftx  out  11  player left column
- rightx  out  11  leftx + PLAYER_W - 1
- state  out  2  GROUND=0, JUMP=1, FALL=2, DESCEND=3
- airborne  out  1  state != GROUND

Behaviour:
Registers and reset
- Registers: x[10:0], y[10:0], state, jump_cnt, vel (0..GRAVITY_MAX), step_cnt.
- Outputs are decoded combinationally from the registers.
- rst_n low (asynchronous, at any time including mid-jump or mid-descent):
  - x=START_X, y=START_Y
  - state=FALL, vel=0, jump_cnt=0, step_cnt=0
  - Resulting outputs: topy=100, bottomy=115, leftx=320, rightx=335, airborne=1.
- Nothing changes except on frame_tick or while in DESCEND.

Horizontal (on frame_tick, any state)
- Exactly one of btn_left/btn_right high: x -= STEP or x += STEP.
- Both or neither high: no move.
- Clamp to 0 .. X_MAX-PLAYER_W+1 (0..624); never wrap.

Vertical state machine
- GROUND, on frame_tick:
  - btn_jump=1 -> JUMP, jump_cnt=JUMP_FRAMES.
  - Else collide=0 and bottomy<Y_MAX -> FALL, vel=0.
  - Else stay.
- JUMP, on frame_tick:
  - If jump_cnt=0 or y<STEP -> FALL, vel=0, no vertical move.
  - Else y -= STEP, jump_cnt -= 1.
  - collide ignored while rising.
- FALL, on frame_tick:
  - vel = min(vel+1, GRAVITY_MAX), step_cnt = new vel.
  - -> DESCEND.
- DESCEND, every clock:
  - collide=1 -> GROUND, vel=0, step_cnt=0, y unchanged.
  - Else bottomy=Y_MAX -> GROUND, vel=0.
  - Else step_cnt=0 -> FALL.
  - Else y += 1, step_cnt -= 1.

Timing
- The collide check in DESCEND uses the current-cycle collide, which reflects the registers of that cycle. Descent therefore stops at the exact landing row.
- DESCEND lasts at most GRAVITY_MAX+1 cycles.
- frame_tick during DESCEND: horizontal move still applies; vertical tick is ignored and descent continues.
- btn_jump in JUMP/FALL/DESCEND: ignored; no double jump.
- Jump and horizontal on the same tick: both apply.

Arithmetic
- 11-bit unsigned throughout.
- Clamps are computed before the register update, so no value ever wraps.

Decomposition:
- Shared package holds:
  - State encoding constants (GROUND/JUMP/FALL/DESCEND).
  - Screen limits (X_MAX=639, Y_MAX=479).
  - The 11-bit coordinate width.
  - The 44-bit wall bundle field order: [43:33] bottom, [32:22] top, [21:11] right, [10:0] left.
- One sub-module is natural: player_hstep (combinational left/right step plus clamp).
- The vertical FSM stays in player_motion.

Test Plan:
- Reset mid-descent (assert rst_n=0 during DESCEND) -> outputs immediately 100/115/320/335, state=FALL.
- Hold btn_right for 200 frame_ticks from reset -> leftx steps by 2 each tick, saturates at 624, rightx=639, never wraps.
- Both buttons held for 5 ticks -> leftx unchanged.
- Wall with top row 140 spanning x 300..400; collide model drives 1 when bottomy+1=140 -> falls from reset with vel 1,2,3,4,4..., stops at bottomy=139, state=GROUND, no overshoot.
- On ground at bottomy=139, btn_jump pulsed -> 20 ticks of topy -= 2 (topy 124 -> 84), then FALL back down to bottomy=139.
- btn_jump held during FALL -> no second jump.
- Walk off the wall edge (leftx > 400) -> collide=0 on next tick -> FALL.
- With no wall, player lands at bottomy=479.
- Jump from topy=10 -> y<STEP ends the rise before topy goes negative; topy stays >= 0.
